// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore-style control unit for a multicycle RV32I datapath. It steps each
//   instruction through FETCH / DECODE / EXECUTE / MEM / WB and drives every
//   datapath strobe. A ready handshake on the shared instruction/data memory
//   stalls the sequence. The unit also handles I-type ALU ops, bne and
//   illegal opcodes.
//
//   Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
//     defined   : an unknown opcode in DECODE enters TRAP. TRAP drives every
//                 strobe low, raises the sticky illegal_instr flag and is left
//                 only through reset.
//     undefined : an unknown opcode executes as a NOP (the PC was already
//                 advanced by 4). illegal_instr is tied low.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   op, funct3            opcode and funct3 fields from the instruction register
//   mem_ready             memory finished the current access this cycle
//   zero                  ALU zero flag
//   pc_write              branch taken, or PC update
//   ir_write              latch the fetched instruction
//   adr_src               memory address select (0=PC, 1=ALU result)
//   mem_write             store strobe
//   reg_write             register file write enable
//   result_src            00=ALUOut, 01=mem data, 10=ALU result
//   alu_src_a             00=PC, 01=OldPC, 10=rs1
//   alu_src_b             00=rs2, 01=imm, 10=const 4
//   alu_op                00=add, 01=sub, 10=funct decoded
//   imm_src               immediate format select (decoded combinationally from op)
//   illegal_instr         sticky illegal-opcode flag
module multicycle_controller #(
  parameter int STATE_W   = 4,
  parameter int IMM_SRC_W = 3,
  parameter int ALUOP_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 mem_ready,
  input  logic                 zero,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic                 illegal_instr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic               ir_write;
    logic               pc_update;
    logic               fetch;      // marks FETCH so pc_update can be gated by mem_ready
    logic               branch;
    logic               adr_src;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  state_t state;
  ctrl_t  ctrl_reg;
  logic   taken;

  function automatic state_t next_of(input state_t s, input logic [6:0] o, input logic rdy);
    case (s)
      S_FETCH:    return rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (o)
          OP_LOAD, OP_STORE: return S_MEMADR;
          OP_RTYPE:          return S_EXECUTER;
          OP_ITYPE:          return S_EXECUTEI;
          OP_BRANCH:         return S_BRANCH;
          OP_JAL:            return S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:           return S_TRAP;
`else
          default:           return S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   return o[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    return S_FETCH;
      S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: return S_ALUWB;
      S_EXECUTEI: return S_ALUWB;
      S_ALUWB:    return S_FETCH;
      S_BRANCH:   return S_FETCH;
      S_JAL:      return S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     return S_TRAP;
`endif
      default:    return S_FETCH;
    endcase
  endfunction

  // Moore strobes per state; anything not named stays 0.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.pc_update = 1'b1; c.fetch = 1'b1;
        c.result_src = 2'b10; c.alu_src_b = 2'b10;
      end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = ALUOP_W'(2); end
      S_EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = ALUOP_W'(2); end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = ALUOP_W'(1); c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state so they line up with the
  // state they describe. The reset value is FETCH's strobe set; the output
  // stage masks everything while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      ctrl_reg <= ctrl_of(S_FETCH);
    end else begin
      state    <= next_of(state, op, mem_ready);
      ctrl_reg <= ctrl_of(next_of(state, op, mem_ready));
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_reg <= 1'b0;
    else       illegal_reg <= illegal_reg | (next_of(state, op, mem_ready) == S_TRAP);
  end
  assign illegal_instr = illegal_reg & ~reset;
`else
  assign illegal_instr = 1'b0;
`endif

  // Only beq (000) and bne (001) can be taken.
  assign taken = ctrl_reg.branch & ~funct3[2] & ~funct3[1] & (zero ^ funct3[0]);

  assign pc_write   = ~reset & ((ctrl_reg.pc_update & (mem_ready | ~ctrl_reg.fetch)) | taken);
  assign ir_write   = ~reset & ctrl_reg.ir_write & mem_ready;
  assign adr_src    = ~reset & ctrl_reg.adr_src;
  assign mem_write  = ~reset & ctrl_reg.mem_write;
  assign reg_write  = ~reset & ctrl_reg.reg_write;
  assign result_src = reset ? 2'b00 : ctrl_reg.result_src;
  assign alu_src_a  = reset ? 2'b00 : ctrl_reg.alu_src_a;
  assign alu_src_b  = reset ? 2'b00 : ctrl_reg.alu_src_b;
  assign alu_op     = reset ? '0 : ctrl_reg.alu_op;

  always_comb begin
    imm_src = '0;
    if (!reset) begin
      case (op)
        OP_STORE:  imm_src = IMM_SRC_W'(1);
        OP_BRANCH: imm_src = IMM_SRC_W'(2);
        OP_JAL:    imm_src = IMM_SRC_W'(3);
        default:   imm_src = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       mem_ready, zero;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .zero(zero), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  int n_cmp = 0;
  int n_bad = 0;

  // Trace vector: {pc_write, ir_write, adr_src, mem_write, reg_write,
  //                result_src[1:0], a[1:0], b[1:0], alu_op[1:0], imm_src[2:0], illegal}
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  logic        rdy_q[$];

  function automatic logic [16:0] observe();
    return {pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == SW) return 3'd1;
    if (o == BR) return 3'd2;
    if (o == JL) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic adr,
      input logic mw, input logic rw, input logic [1:0] rs, input logic [1:0] a,
      input logic [1:0] b, input logic [1:0] alu, input logic [2:0] im);
    return {pcw, irw, adr, mw, rw, rs, a, b, alu, im, 1'b0};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom & 1);
  endfunction

  // Reference: expected cycle-by-cycle strobes for one instruction, built from
  // the per-phase strobe table. mem_ready is only meaningful in memory phases;
  // elsewhere it is randomised to show it has no effect.
  task automatic model_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input int fst, input int mst);
    logic [2:0] im;
    logic       tk;
    im = imm_of(o);
    tk = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
    exp_q.delete(); rdy_q.delete();
    for (int i = 0; i < fst; i++) begin
      rdy_q.push_back(1'b0); exp_q.push_back(mk(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,im));
    end
    rdy_q.push_back(1'b1); exp_q.push_back(mk(1,1,0,0,0,2'd2,2'd0,2'd2,2'd0,im));
    rdy_q.push_back(rnd_bit()); exp_q.push_back(mk(0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,im));
    case (o)
      LW, SW: begin
        rdy_q.push_back(rnd_bit()); exp_q.push_back(mk(0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,im));
        for (int i = 0; i <= mst; i++) begin
          rdy_q.push_back(i == mst);
          exp_q.push_back(mk(0,0,1,(o == SW),0,2'd0,2'd0,2'd0,2'd0,im));
        end
        if (o == LW) begin
          rdy_q.push_back(rnd_bit()); exp_q.push_back(mk(0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,im));
        end
      end
      RT, IT, JL: begin
        rdy_q.push_back(rnd_bit());
        if (o == JL) exp_q.push_back(mk(1,0,0,0,0,2'd0,2'd1,2'd2,2'd0,im));
        else         exp_q.push_back(mk(0,0,0,0,0,2'd0,2'd2,(o == IT) ? 2'd1 : 2'd0,2'd2,im));
        rdy_q.push_back(rnd_bit()); exp_q.push_back(mk(0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,im));
      end
      BR: begin
        rdy_q.push_back(rnd_bit()); exp_q.push_back(mk(tk,0,0,0,0,2'd0,2'd2,2'd0,2'd1,im));
      end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin
          rdy_q.push_back(rnd_bit()); exp_q.push_back(17'h1);
        end
`endif
      end
    endcase
  endtask

  // Drive up to n cycles of the modelled trace and capture the outputs.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic z, input int n);
    obs_q.delete();
    for (int i = 0; i < rdy_q.size() && i < n; i++) begin
      @(negedge clk);
      op = o; funct3 = f3; zero = z; mem_ready = rdy_q[i];
      #1;
      obs_q.push_back(observe());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 7'($urandom); funct3 = 3'd0; mem_ready = 1'b1; zero = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++;
      if (observe() !== 17'h0) begin
        n_bad++; $display("FAIL reset_outputs got %h want %h", observe(), 17'h0);
      end
    end
    @(negedge clk);
    reset = 1'b0; op = SW; mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (observe() !== mk(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd1)) begin
      n_bad++; $display("FAIL reset_release_fetch got %h", observe());
    end
    $display("reset: checked outputs low during reset and FETCH after release");
  endtask

  task automatic test_lw();
    model_instr(LW, 3'd0, 1'b0, 0, 0);
    run(LW, 3'd0, 1'b0, 1000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL lw cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_q[4][12] !== 1'b1 || obs_q[4][11:10] !== 2'b01) begin
      n_bad++; $display("FAIL lw_wb got rw=%b rs=%b want rw=1 rs=01", obs_q[4][12], obs_q[4][11:10]);
    end
    $display("lw: %0d cycles", obs_q.size());
  endtask

  task automatic test_sw_stall();
    model_instr(SW, 3'd2, 1'b0, 0, 3);
    run(SW, 3'd2, 1'b0, 1000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL sw cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 3; i < 7; i++) begin
      n_cmp++;
      if (obs_q[i][14:13] !== 2'b11) begin
        n_bad++; $display("FAIL sw_hold cyc%0d got adr/mw=%b want 11", i, obs_q[i][14:13]);
      end
    end
    $display("sw with 3 stalls: %0d cycles", obs_q.size());
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      model_instr(BR, 3'(k), 1'b1, 0, 0);
      run(BR, 3'(k), 1'b1, 1000);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL branch f3=%0d cyc%0d got %h want %h", k, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (obs_q[2][16] !== (k == 0)) begin
        n_bad++; $display("FAIL branch_taken f3=%0d got %b want %b", k, obs_q[2][16], k == 0);
      end
      $display("branch f3=%0d zero=1: pc_write=%b", k, obs_q[2][16]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [2];
    ops[0] = IT; ops[1] = RT;
    for (int k = 0; k < 2; k++) begin
      model_instr(ops[k], 3'd0, 1'b0, 0, 0);
      run(ops[k], 3'd0, 1'b0, 1000);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL alu op=%b cyc%0d got %h want %h", ops[k], i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (obs_q[2][7:6] !== ((k == 0) ? 2'b01 : 2'b00) || obs_q[2][5:4] !== 2'b10) begin
        n_bad++; $display("FAIL alu_exec op=%b got b=%b aluop=%b", ops[k], obs_q[2][7:6], obs_q[2][5:4]);
      end
      $display("alu op=%b: %0d cycles", ops[k], obs_q.size());
    end
  endtask

  task automatic test_jal();
    model_instr(JL, 3'd0, 1'b0, 1, 0);
    run(JL, 3'd0, 1'b0, 1000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL jal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_q[3][16] !== 1'b1 || obs_q[3][3:1] !== 3'b011) begin
      n_bad++; $display("FAIL jal_pc got pcw=%b imm=%b want 1/011", obs_q[3][16], obs_q[3][3:1]);
    end
    $display("jal with fetch stall: %0d cycles", obs_q.size());
  endtask

  task automatic test_illegal();
    model_instr(BAD, 3'd0, 1'b0, 0, 0);
    run(BAD, 3'd0, 1'b0, 1000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL illegal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    @(negedge clk); reset = 1'b1; #1; @(negedge clk); reset = 1'b0;
`endif
    // Next instruction must start from FETCH.
    model_instr(IT, 3'd0, 1'b0, 0, 0);
    run(IT, 3'd0, 1'b0, 1000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL after_illegal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    $display("illegal opcode handled, next instruction fetched");
  endtask

  task automatic test_reset_mid_store();
    model_instr(SW, 3'd2, 1'b0, 0, 3);
    run(SW, 3'd2, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL mid_store cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (observe() !== 17'h0) begin
      n_bad++; $display("FAIL reset_async got %h want %h", observe(), 17'h0);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (observe() !== mk(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd1)) begin
      n_bad++; $display("FAIL reset_mid_fetch got %h", observe());
    end
    $display("reset mid-store: outputs cleared, FETCH after release");
  endtask

  task automatic test_random();
    logic [6:0] tbl [7];
    logic [6:0] o;
    logic [2:0] f3;
    logic       z;
    int         fst, mst, nops;
    tbl[0] = LW; tbl[1] = SW; tbl[2] = RT; tbl[3] = IT; tbl[4] = BR; tbl[5] = JL; tbl[6] = BAD;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    nops = 6;
`else
    nops = 7;
`endif
    for (int t = 0; t < 40; t++) begin
      o   = tbl[$urandom_range(0, nops - 1)];
      f3  = 3'($urandom_range(0, 7));
      z   = rnd_bit();
      fst = $urandom_range(0, 3);
      mst = $urandom_range(0, 3);
      model_instr(o, f3, z, fst, mst);
      run(o, f3, z, 1000);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rand t%0d op=%b cyc%0d got %h want %h", t, o, i, obs_q[i], exp_q[i]);
        end
      end
      $display("rand t%0d op=%b f3=%0d zero=%b stalls=%0d/%0d cycles=%0d", t, o, f3, z, fst, mst, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_back_to_back();
    test_jal();
    test_illegal();
    test_reset_mid_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
